// File: rtl/reflet_float_queue.sv
// rtl/reflet_float_queue.sv - command FIFO, issue FSM and result register in front of reflet_float_au
//
// reflet_float_au: multi-cycle float unit. enable starts an operation on the
//   rising edge it is first seen. ready/flt_out/cmp_flag hold their last values
//   while enable is low, so ready can still be high when the next op begins.
//   opcodes: 0 add, 1 sub, 2 compare (ctrl 0 eq, 1 lt, 2 le, 3 gt), 3 select
//   (ctrl[0] ? in3 : in1). Any other opcode never completes.
//
// reflet_float_queue ports:
//   clk, reset                 clock, synchronous active-high reset
//   in_valid/in_ready          command handshake; in_opcode, in_ctrl, in_a,
//                              in_b, in_c, in_tag carry the command
//   out_valid/out_ready        result handshake; out_result, out_cmp, out_tag,
//                              out_err carry the result
//   busy                       FIFO non-empty or FSM not idle
// Optional: REFLET_FLOAT_QUEUE_TIMEOUT_EN adds a WAIT watchdog of
//   timeout_cycles that returns out_err=1 with a zero result.

module reflet_float_au #(
    parameter int float_size = 32,
    parameter int latency    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [5:0]            opcode,
    input  logic [1:0]            ctrl_flag,
    input  logic [float_size-1:0] flt_in1,
    input  logic [float_size-1:0] flt_in2,
    input  logic [float_size-1:0] flt_in3,
    output logic [float_size-1:0] flt_out,
    output logic                  cmp_flag,
    output logic                  ready
);
    localparam int ew = (float_size == 64) ? 11 : (float_size == 16) ? 5 : 8;
    localparam int mw = float_size - 1 - ew;
    localparam int sw = mw + 5;  // carry + hidden + mantissa + 3 guard bits
    localparam logic [5:0] OP_ADD = 6'd0, OP_SUB = 6'd1, OP_CMP = 6'd2, OP_SEL = 6'd3;

    logic                  run_q, ready_q, cmp_q;
    logic [7:0]            cnt_q;
    logic [float_size-1:0] out_q, res_d, add_res;
    logic                  cmp_d, known_op, s1, s2, sx, sy, lt, eq, both_zero, found;
    logic [float_size-2:0] mag1, mag2, mx_raw, my_raw;
    logic [ew-1:0]         ex, ey, er, diff;
    logic [mw:0]           mx, my;
    logic [sw-1:0]         ax, ay, sum, norm;
    int                    lz;

    always_comb begin
        s1   = flt_in1[float_size-1];
        s2   = flt_in2[float_size-1] ^ (opcode == OP_SUB);
        mag1 = flt_in1[float_size-2:0];
        mag2 = flt_in2[float_size-2:0];
        // larger magnitude becomes x so the aligned subtraction never goes negative
        if (mag1 >= mag2) begin
            sx = s1; sy = s2; mx_raw = mag1; my_raw = mag2;
        end else begin
            sx = s2; sy = s1; mx_raw = mag2; my_raw = mag1;
        end
        ex   = mx_raw[float_size-2:mw];
        ey   = my_raw[float_size-2:mw];
        mx   = {|ex, mx_raw[mw-1:0]};
        my   = {|ey, my_raw[mw-1:0]};
        diff = ex - ey;
        ax   = {1'b0, mx, 3'b000};
        ay   = (int'(diff) >= sw) ? '0 : ({1'b0, my, 3'b000} >> diff);
        sum  = (sx == sy) ? ax + ay : ax - ay;
        lz    = 0;
        found = 1'b0;
        for (int i = sw - 2; i >= 0; i--) begin
            if (!found && sum[i]) found = 1'b1;
            else if (!found) lz = lz + 1;
        end
        if (sum[sw-1]) begin
            norm = sum >> 1;
            er   = ex + ew'(1);
        end else begin
            norm = sum << lz;
            er   = ex - ew'(lz);
        end
        // exact cancellation and underflow flush to +0; the result is truncated
        if (sum == '0 || (!sum[sw-1] && lz >= int'(ex))) add_res = '0;
        else add_res = {sx, er, norm[sw-3:3]};

        both_zero = (flt_in1[float_size-2:0] == '0) && (flt_in2[float_size-2:0] == '0);
        eq = (flt_in1 == flt_in2) || both_zero;
        if (flt_in1[float_size-1] != flt_in2[float_size-1]) lt = flt_in1[float_size-1] && !both_zero;
        else if (flt_in1[float_size-1]) lt = mag1 > mag2;
        else lt = mag1 < mag2;

        res_d = '0;
        cmp_d = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB: res_d = add_res;
            OP_CMP: begin
                case (ctrl_flag)
                    2'd0:    cmp_d = eq;
                    2'd1:    cmp_d = lt;
                    2'd2:    cmp_d = lt | eq;
                    default: cmp_d = !(lt | eq);
                endcase
            end
            OP_SEL: res_d = ctrl_flag[0] ? flt_in3 : flt_in1;
            default: res_d = '0;
        endcase
        known_op = (opcode <= OP_SEL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q   <= 1'b0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            out_q   <= '0;
            cmp_q   <= 1'b0;
        end else if (!enable) begin
            run_q <= 1'b0;
        end else if (!run_q) begin
            run_q   <= 1'b1;
            ready_q <= 1'b0;
            cnt_q   <= 8'(latency - 1);
        end else if (!ready_q && known_op) begin
            if (cnt_q == 8'd0) begin
                ready_q <= 1'b1;
                out_q   <= res_d;
                cmp_q   <= cmp_d;
            end else begin
                cnt_q <= cnt_q - 8'd1;
            end
        end
    end

    assign flt_out  = out_q;
    assign cmp_flag = cmp_q;
    assign ready    = ready_q;
endmodule

module reflet_float_queue #(
    parameter int float_size     = 32,
    parameter int depth          = 4,
    parameter int tag_width      = 4,
    parameter int timeout_cycles = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [5:0]            in_opcode,
    input  logic [1:0]            in_ctrl,
    input  logic [float_size-1:0] in_a,
    input  logic [float_size-1:0] in_b,
    input  logic [float_size-1:0] in_c,
    input  logic [tag_width-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [float_size-1:0] out_result,
    output logic                  out_cmp,
    output logic [tag_width-1:0]  out_tag,
    output logic                  out_err,
    output logic                  busy
);
    localparam int aw = $clog2(depth);

    typedef struct packed {
        logic [5:0]            opcode;
        logic [1:0]            ctrl;
        logic [float_size-1:0] a;
        logic [float_size-1:0] b;
        logic [float_size-1:0] c;
        logic [tag_width-1:0]  tag;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_WAIT, S_HOLD} state_t;

    cmd_t                  mem_q [depth];
    cmd_t                  issue_q;
    state_t                state_q;
    logic [aw-1:0]         wr_ptr_q, rd_ptr_q;
    logic [aw:0]           count_q, count_d;
    logic                  push, pop, au_enable, au_ready, au_cmp;
    logic [float_size-1:0] au_out;

    // in_ready looks only at the registered count: a pop never frees a slot early
    assign in_ready  = !reset && (count_q < (aw+1)'(depth));
    assign push      = in_valid && in_ready;
    assign pop       = (count_q != '0) &&
                       ((state_q == S_IDLE) || (state_q == S_HOLD && out_ready));
    assign au_enable = (state_q == S_SETTLE) || (state_q == S_WAIT);
    assign busy      = (count_q != '0) || (state_q != S_IDLE);

    always_comb begin
        count_d = count_q;
        if (push && !pop) count_d = count_q + (aw+1)'(1);
        else if (pop && !push) count_d = count_q - (aw+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{in_opcode, in_ctrl, in_a, in_b, in_c, in_tag};
    end

`ifdef REFLET_FLOAT_QUEUE_TIMEOUT_EN
    localparam int tw = $clog2(timeout_cycles + 1);
    logic [tw-1:0] tmo_q;
`else
    logic unused_timeout;
    assign unused_timeout = (timeout_cycles != 0);
    assign out_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            issue_q    <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_cmp    <= 1'b0;
            out_tag    <= '0;
`ifdef REFLET_FLOAT_QUEUE_TIMEOUT_EN
            out_err    <= 1'b0;
            tmo_q      <= '0;
`endif
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + aw'(1);
            if (pop) begin
                issue_q  <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + aw'(1);
            end
`ifdef REFLET_FLOAT_QUEUE_TIMEOUT_EN
            if (pop) tmo_q <= '0;
            else if (state_q == S_WAIT) tmo_q <= tmo_q + tw'(1);
`endif
            case (state_q)
                S_IDLE:   if (pop) state_q <= S_SETTLE;
                // ready may still be high from the previous op; never look at it here
                S_SETTLE: state_q <= S_WAIT;
                S_WAIT: begin
                    if (au_ready) begin
                        out_result <= au_out;
                        out_cmp    <= au_cmp;
                        out_tag    <= issue_q.tag;
                        out_valid  <= 1'b1;
`ifdef REFLET_FLOAT_QUEUE_TIMEOUT_EN
                        out_err    <= 1'b0;
`endif
                        state_q    <= S_HOLD;
                    end
`ifdef REFLET_FLOAT_QUEUE_TIMEOUT_EN
                    else if (tmo_q == tw'(timeout_cycles - 1)) begin
                        out_result <= '0;
                        out_cmp    <= 1'b0;
                        out_tag    <= issue_q.tag;
                        out_valid  <= 1'b1;
                        out_err    <= 1'b1;
                        state_q    <= S_HOLD;
                    end
`endif
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= pop ? S_SETTLE : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    reflet_float_au #(.float_size(float_size)) u_au (
        .clk       (clk),
        .reset     (reset),
        .enable    (au_enable),
        .opcode    (issue_q.opcode),
        .ctrl_flag (issue_q.ctrl),
        .flt_in1   (issue_q.a),
        .flt_in2   (issue_q.b),
        .flt_in3   (issue_q.c),
        .flt_out   (au_out),
        .cmp_flag  (au_cmp),
        .ready     (au_ready)
    );
endmodule
